// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache responder.
// Loads refill whole lines beat by beat; stores go out through a one-entry write buffer.
module dcache_responder #(
    parameter int LINES  = 64,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_re,
    input  logic [3:0]        dcache_we,
    input  logic [31:0]       dcache_din,
    output logic [31:0]       dcache_dout,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rnw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_data,
    output logic [3:0]        mem_req_mask,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int LSB   = OFF_W + 2;
    localparam int TAG_W = ADDR_W - LSB - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        WB_DRAIN,
        REFILL_REQ,
        REFILL_DATA,
        DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:2] r_reqAddr;
    logic              r_reqRe;
    logic [3:0]        r_reqWe;
    logic [31:0]       r_reqDin;
    logic [ADDR_W-1:2] r_wbAddr;
    logic [31:0]       r_wbData;
    logic [3:0]        r_wbMask;
    logic              r_wbValid;
    logic [OFF_W-1:0]  r_beat;
    logic [31:0]       r_dout;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [31:0]       r_data [LINES*WORDS];

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic [31:0]       w_word;
    logic [31:0]       w_merged;
    logic              w_isStore;
    logic              w_isLoad;
    logic              w_inIdle;
    logic              w_loadHit;
    logic              w_loadMiss;
    logic              w_wbIssue;
    logic              w_wbAccept;
    logic              w_storeEnter;
    logic              w_storeWait;
    logic              w_lastBeat;
    logic              w_unused;

    // Byte-offset bits never matter for word accesses.
    assign w_unused = ^dcache_addr[1:0];

    assign w_off  = r_reqAddr[LSB-1:2];
    assign w_idx  = r_reqAddr[LSB+IDX_W-1:LSB];
    assign w_tag  = r_reqAddr[ADDR_W-1:LSB+IDX_W];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_word = r_data[{w_idx, w_off}];

    // A store always wins over a simultaneous load in the same request.
    assign w_isStore = |r_reqWe;
    assign w_isLoad  = r_reqRe && !w_isStore;
    assign w_inIdle  = (r_state == IDLE);

    assign w_loadHit    = w_inIdle && w_isLoad && w_hit;
    assign w_loadMiss   = w_inIdle && w_isLoad && !w_hit;
    assign w_wbIssue    = r_wbValid && (r_state == IDLE || r_state == WB_DRAIN);
    assign w_wbAccept   = w_wbIssue && mem_req_ready;
    assign w_storeEnter = w_inIdle && w_isStore && (!r_wbValid || w_wbAccept);
    assign w_storeWait  = w_inIdle && w_isStore && r_wbValid && !w_wbAccept;
    assign w_lastBeat   = (r_state == REFILL_DATA) && mem_resp_valid &&
                          (r_beat == OFF_W'(WORDS - 1));

    always_comb begin
        w_merged = w_word;
        for (int i = 0; i < 4; i++) begin
            if (r_reqWe[i]) begin
                w_merged[8*i +: 8] = r_reqDin[8*i +: 8];
            end
        end
    end

    always_comb begin
        stall = 1'b0;
        case (r_state)
            IDLE:    stall = w_loadMiss || w_storeWait;
            DONE:    stall = 1'b0;
            default: stall = 1'b1;
        endcase
    end

    // Outside a hit or the DONE cycle the last delivered load word is held.
    assign dcache_dout = (w_loadHit || r_state == DONE) ? w_word : r_dout;

    assign mem_req_valid = w_wbIssue || (r_state == REFILL_REQ);
    assign mem_req_rnw   = (r_state == REFILL_REQ);
    assign mem_req_addr  = mem_req_rnw ? {r_reqAddr[ADDR_W-1:LSB], {LSB{1'b0}}}
                                       : {r_wbAddr, 2'b00};
    assign mem_req_data  = r_wbData;
    assign mem_req_mask  = r_wbMask;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_storeEnter && w_hit) begin
                r_data[{w_idx, w_off}] <= w_merged;
            end
            if (r_state == REFILL_DATA && mem_resp_valid) begin
                r_data[{w_idx, r_beat}] <= mem_resp_data;
            end
            if (w_lastBeat) begin
                r_tag[w_idx] <= w_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_reqAddr <= '0;
            r_reqRe   <= 1'b0;
            r_reqWe   <= '0;
            r_reqDin  <= '0;
            r_wbAddr  <= '0;
            r_wbData  <= '0;
            r_wbMask  <= '0;
            r_wbValid <= 1'b0;
            r_beat    <= '0;
            r_dout    <= '0;
            r_valid   <= '0;
        end else begin
            r_dout <= dcache_dout;
            if (!stall) begin
                r_reqAddr <= dcache_addr[ADDR_W-1:2];
                r_reqRe   <= dcache_re;
                r_reqWe   <= dcache_we;
                r_reqDin  <= dcache_din;
            end
            if (w_storeEnter) begin
                r_wbValid <= 1'b1;
                r_wbAddr  <= r_reqAddr;
                r_wbData  <= r_reqDin;
                r_wbMask  <= r_reqWe;
            end else if (w_wbAccept) begin
                r_wbValid <= 1'b0;
            end
            // A buffer entry accepted in the miss cycle needs no separate drain.
            case (r_state)
                IDLE: begin
                    if (w_loadMiss) begin
                        r_state <= (r_wbValid && !w_wbAccept) ? WB_DRAIN : REFILL_REQ;
                    end
                end
                WB_DRAIN: begin
                    if (w_wbAccept) begin
                        r_state <= REFILL_REQ;
                    end
                end
                REFILL_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= REFILL_DATA;
                        r_beat  <= '0;
                    end
                end
                REFILL_DATA: begin
                    if (mem_resp_valid) begin
                        r_beat <= r_beat + OFF_W'(1);
                        if (w_lastBeat) begin
                            r_valid[w_idx] <= 1'b1;
                            r_state        <= DONE;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
